// File: rtl/kernel_window_sequencer.sv
// Control FSM that walks a KernelAccumulator over a SIZE x SIZE window, one element
// per INDEX/ISSUE/WAIT pass, and hands the captured sum back over valid/ready.
module kernel_window_sequencer #(
  parameter logic [3:0] SIZE    = 4'd3,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       go,
  input  logic       abort,
  output logic       busy,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic       en_strobe,
  output logic       acc_clear,
  output logic       acc_start,
  input  logic       acc_ready,
  input  logic [7:0] acc_sum,
  output logic [7:0] result,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INDEX,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX   = SIZE - 4'd1;
  localparam logic [7:0] WAIT_LIMIT = TIMEOUT - 8'd1;

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic       last_elem;
  logic       timed_out;

  assign last_elem = (cur_x == LAST_IDX) && (cur_y == LAST_IDX);
  assign timed_out = (wait_cnt == WAIT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (go) next_state = S_CLEAR;
        S_CLEAR: next_state = S_INDEX;
        S_INDEX: next_state = S_ISSUE;
        S_ISSUE: next_state = S_WAIT;
        S_WAIT: begin
          if (acc_ready)      next_state = last_elem ? S_DONE : S_INDEX;
          else if (timed_out) next_state = S_DONE;
        end
        S_DONE:  if (result_ready) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b0;
    en_strobe    = 1'b0;
    acc_clear    = 1'b0;
    acc_start    = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE:  ;
      S_CLEAR: begin busy = 1'b1; acc_clear    = 1'b1; end
      S_INDEX: begin busy = 1'b1; en_strobe    = 1'b1; end
      S_ISSUE: begin busy = 1'b1; acc_start    = 1'b1; end
      S_WAIT:  busy = 1'b1;
      S_DONE:  begin busy = 1'b1; result_valid = 1'b1; end
      default: ;
    endcase
  end

  // Datapath updates are keyed on the chosen transition, so abort (which forces
  // next_state to IDLE) suppresses index advance and result capture for free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur_x       <= '0;
      cur_y       <= '0;
      wait_cnt    <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && next_state == S_CLEAR) begin
        cur_x <= '0;
        cur_y <= '0;
      end else if (state == S_WAIT && next_state == S_INDEX) begin
        if (cur_x == LAST_IDX) begin
          cur_x <= '0;
          cur_y <= cur_y + 4'd1;
        end else begin
          cur_x <= cur_x + 4'd1;
        end
      end

      if (next_state == S_CLEAR || state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT && !acc_ready && !timed_out)
        wait_cnt <= wait_cnt + 8'd1;

      if (state == S_WAIT && next_state == S_DONE) begin
        result      <= acc_ready ? acc_sum : 8'h00;
        timeout_err <= !acc_ready;
      end
    end
  end

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// Self-checking bench: a behavioural accumulator model feeds the sequencer, and a
// scoreboard of expected window results is compared when result_valid rises.
module tb_kernel_window_sequencer;

  localparam int SZ = 3;
  localparam int TO = 8;

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         edges;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       go, abort, busy, en_strobe, acc_clear, acc_start, acc_ready;
  logic [3:0] cur_x, cur_y;
  logic [7:0] acc_sum, result;
  logic       result_valid, result_ready, timeout_err;

  logic       go1, abort1, busy1, en_strobe1, acc_clear1, acc_start1, acc_ready1;
  logic [3:0] cur_x1, cur_y1;
  logic [7:0] acc_sum1, result1;
  logic       result_valid1, result_ready1, timeout_err1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t       sb[$];
  logic [7:0] strobe_q[$];
  int         clear_cnt = 0, start_cnt = 0, strobe1_cnt = 0;
  int         multi_hot = 0, wide_pulse = 0, idx1_nonzero = 0;
  logic       prev_strobe = 1'b0;

  int         delay_cfg  = 0;
  int         stuck_elem = -1;
  logic [7:0] final_sum  = 8'h00;
  int         elem, rem;
  logic       stuck;

  always #5 clk = ~clk;

  kernel_window_sequencer #(.SIZE(4'd3), .TIMEOUT(8'd8)) dut (
    .clk(clk), .n_rst(n_rst), .go(go), .abort(abort), .busy(busy),
    .cur_x(cur_x), .cur_y(cur_y), .en_strobe(en_strobe), .acc_clear(acc_clear),
    .acc_start(acc_start), .acc_ready(acc_ready), .acc_sum(acc_sum),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .timeout_err(timeout_err)
  );

  kernel_window_sequencer #(.SIZE(4'd1), .TIMEOUT(8'd8)) dut1 (
    .clk(clk), .n_rst(n_rst), .go(go1), .abort(abort1), .busy(busy1),
    .cur_x(cur_x1), .cur_y(cur_y1), .en_strobe(en_strobe1), .acc_clear(acc_clear1),
    .acc_start(acc_start1), .acc_ready(acc_ready1), .acc_sum(acc_sum1),
    .result(result1), .result_valid(result_valid1), .result_ready(result_ready1),
    .timeout_err(timeout_err1)
  );

  // Accumulator model: ready drops on the start edge for delay_cfg cycles, or
  // forever on the stuck element; the last element returns final_sum.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_ready <= 1'b1; acc_sum <= 8'h00; elem <= 0; rem <= 0; stuck <= 1'b0;
    end else if (acc_clear) begin
      acc_ready <= 1'b1; elem <= 0; rem <= 0; stuck <= 1'b0;
    end else if (acc_start) begin
      elem    <= elem + 1;
      acc_sum <= (elem == SZ*SZ-1) ? final_sum : 8'(elem*7 + 1);
      if (elem == stuck_elem) begin
        stuck <= 1'b1; acc_ready <= 1'b0;
      end else begin
        rem <= delay_cfg; acc_ready <= (delay_cfg == 0);
      end
    end else if (!stuck && rem > 0) begin
      rem <= rem - 1; acc_ready <= (rem == 1);
    end
  end

  always @(negedge clk) begin
    if (en_strobe) strobe_q.push_back({cur_y, cur_x});
    if (acc_clear) clear_cnt <= clear_cnt + 1;
    if (acc_start) start_cnt <= start_cnt + 1;
    if (32'(en_strobe) + 32'(acc_clear) + 32'(acc_start) > 1) multi_hot <= multi_hot + 1;
    if (en_strobe && prev_strobe) wide_pulse <= wide_pulse + 1;
    prev_strobe <= en_strobe;
    if (en_strobe1) strobe1_cnt <= strobe1_cnt + 1;
    if (busy1 && (cur_x1 != 4'd0 || cur_y1 != 4'd0)) idx1_nonzero <= idx1_nonzero + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one window up to DONE and leaves the DUT there for the handshake.
  task automatic run_window(input int delay, input int stk, input logic [7:0] fsum);
    exp_t e;
    int   edges, n_el, c0;
    delay_cfg = delay; stuck_elem = stk; final_sum = fsum;
    e.res   = (stk < 0) ? fsum : 8'h00;
    e.err   = (stk >= 0);
    e.edges = (stk < 0) ? 1 + SZ*SZ*(3 + delay) : 1 + stk*(3 + delay) + 2 + TO;
    n_el    = (stk < 0) ? SZ*SZ : stk + 1;
    sb.push_back(e);
    strobe_q.delete();
    c0 = clear_cnt;
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    check("busy_rise", busy, 1'b1);
    edges = 0;
    while (!result_valid && edges < 400) begin
      @(posedge clk); #1; edges++;
    end
    e = sb.pop_front();
    check("done_edge", edges, e.edges);
    check("result", result, e.res);
    check("timeout_err", timeout_err, e.err);
    @(negedge clk);
    check("strobe_cnt", strobe_q.size(), n_el);
    for (int i = 0; i < n_el && i < strobe_q.size(); i++)
      check("strobe_xy", strobe_q[i], {4'(i / SZ), 4'(i % SZ)});
    check("clear_cnt", clear_cnt - c0, 1);
  endtask

  task automatic handshake(input int hold);
    logic [7:0] r0;
    logic       e0;
    int         bad, s0;
    r0 = result; e0 = timeout_err; bad = 0; s0 = strobe_q.size();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); go = (i == 3 || i == 7);
      @(posedge clk); #1;
      if (result !== r0 || timeout_err !== e0 || result_valid !== 1'b1 || busy !== 1'b1) bad++;
    end
    if (hold > 0) begin
      check("hold_stable", bad, 0);
      check("go_ignored", strobe_q.size(), s0);
    end
    @(negedge clk); go = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_busy", busy, 1'b0);
    check("hs_valid", result_valid, 1'b0);
    @(negedge clk); result_ready = 1'b0;
  endtask

  initial begin
    int cnt, s0, c0;
    logic [7:0] r_prev;
    n_rst = 1'b0; go = 1'b0; abort = 1'b0; result_ready = 1'b0;
    go1 = 1'b0; abort1 = 1'b0; acc_ready1 = 1'b1; acc_sum1 = 8'h3C; result_ready1 = 1'b0;
    #12;
    check("reset_outs", {busy, cur_x, cur_y, en_strobe, acc_clear, acc_start,
                         result, result_valid, timeout_err}, 0);
    @(negedge clk); n_rst = 1'b1;

    run_window(0, -1, 8'h5A);
    handshake(10);
    repeat (3) @(posedge clk);
    #1 check("go_not_queued", busy, 1'b0);

    run_window(0, 1, 8'h77);
    handshake(0);

    run_window(4, -1, 8'hC3);
    handshake(0);

    // Abort during the fifth WAIT.
    r_prev = result;
    delay_cfg = 4; stuck_elem = -1;
    s0 = start_cnt;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cnt = 0;
    while (start_cnt - s0 < 5 && cnt < 200) begin @(negedge clk); cnt++; end
    check("abort_reach", start_cnt - s0, 5);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 1'b0);
    @(negedge clk); abort = 1'b0;
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (result_valid || busy) cnt++; end
    check("abort_no_valid", cnt, 0);
    check("abort_result_hold", result, r_prev);

    // abort and go together in IDLE.
    c0 = clear_cnt;
    @(negedge clk); go = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("abort_go_idle", busy, 1'b0);
    @(negedge clk); go = 1'b0; abort = 1'b0;
    check("abort_go_noclear", clear_cnt - c0, 0);

    // Asynchronous reset mid-window, then a clean restart.
    delay_cfg = 0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (8) @(posedge clk);
    #2 n_rst = 1'b0;
    #1 check("async_reset", {busy, cur_x, cur_y, en_strobe, acc_clear, acc_start,
                             result, result_valid, timeout_err}, 0);
    @(negedge clk); n_rst = 1'b1;
    run_window(0, -1, 8'h5A);
    handshake(0);

    // SIZE=1 instance: single pass at (0,0).
    @(negedge clk); go1 = 1'b1;
    @(posedge clk); #1; go1 = 1'b0;
    cnt = 0;
    while (!result_valid1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    check("s1_done_edge", cnt, 4);
    check("s1_result", result1, 8'h3C);
    check("s1_strobes", strobe1_cnt, 1);
    check("s1_idx_zero", idx1_nonzero, 0);
    @(negedge clk); result_ready1 = 1'b1;
    @(posedge clk); #1 check("s1_idle", busy1, 1'b0);
    @(negedge clk); result_ready1 = 1'b0;

    check("strobe_exclusive", multi_hot, 0);
    check("strobe_width", wide_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
